// File: rtl/maxpool1_layer.sv
// 2x2 stride-2 signed max-pooling over three channels, raster-order input with stalls.
// Optional MAXPOOL1_RELU_EN clamps negative pooled results to zero before registering.
module maxpool1_layer #(
   parameter int IMG_W  = 24,
   parameter int IMG_H  = 24,
   parameter int DATA_W = 12
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid_in,
   input  logic signed [DATA_W-1:0] conv_out_1,
   input  logic signed [DATA_W-1:0] conv_out_2,
   input  logic signed [DATA_W-1:0] conv_out_3,
   output logic signed [DATA_W-1:0] max_value_1,
   output logic signed [DATA_W-1:0] max_value_2,
   output logic signed [DATA_W-1:0] max_value_3,
   output logic                     valid_out_pool,
   output logic                     frame_done
);

   localparam int HALF_W = IMG_W / 2;
   localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int BW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;

   function automatic logic signed [DATA_W-1:0] max2(input logic signed [DATA_W-1:0] a,
                                                     input logic signed [DATA_W-1:0] b);
      max2 = (a > b) ? a : b;
   endfunction

   function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] v);
`ifdef MAXPOOL1_RELU_EN
      relu = v[DATA_W-1] ? {DATA_W{1'b0}} : v;
`else
      relu = v;
`endif
   endfunction

   logic [CW-1:0]            col_q, col_d;
   logic [RW-1:0]            row_q, row_d;
   logic signed [DATA_W-1:0] hold_q [3];
   logic signed [DATA_W-1:0] hold_d [3];
   logic signed [DATA_W-1:0] max_q  [3];
   logic signed [DATA_W-1:0] max_d  [3];
   logic signed [DATA_W-1:0] pix_s  [3];
   logic signed [DATA_W-1:0] lb_rd_s [3];
   logic signed [DATA_W-1:0] lb_wr_s [3];
   logic signed [DATA_W-1:0] linebuf_q [3][HALF_W];
   logic                     valid_q, valid_d;
   logic                     done_q, done_d;
   logic                     lb_we_s;
   logic [BW-1:0]            lb_idx_s;
   logic                     col_last_s, row_last_s;

   assign pix_s[0] = conv_out_1;
   assign pix_s[1] = conv_out_2;
   assign pix_s[2] = conv_out_3;

   assign col_last_s = (col_q == CW'(IMG_W - 1));
   assign row_last_s = (row_q == RW'(IMG_H - 1));
   assign lb_idx_s   = BW'(col_q >> 1);

   // Next-state: raster counters, per-parity hold/line-buffer/output updates
   always_comb begin
      col_d   = col_q;
      row_d   = row_q;
      hold_d  = hold_q;
      max_d   = max_q;
      valid_d = 1'b0;
      done_d  = 1'b0;
      lb_we_s = 1'b0;
      for (int c = 0; c < 3; c++) begin
         lb_rd_s[c] = linebuf_q[c][lb_idx_s];
         lb_wr_s[c] = max2(hold_q[c], pix_s[c]);
      end
      if (valid_in) begin
         if (col_last_s) begin
            col_d = {CW{1'b0}};
            row_d = row_last_s ? {RW{1'b0}} : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
         if (!col_q[0]) begin
            hold_d = pix_s;
         end else if (!row_q[0]) begin
            lb_we_s = 1'b1;
         end else begin
            for (int c = 0; c < 3; c++) begin
               max_d[c] = relu(max2(lb_rd_s[c], lb_wr_s[c]));
            end
            valid_d = 1'b1;
            done_d  = row_last_s && col_last_s;
         end
      end else begin
         lb_we_s = 1'b0;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         col_q   <= {CW{1'b0}};
         row_q   <= {RW{1'b0}};
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         for (int c = 0; c < 3; c++) begin
            hold_q[c] <= {DATA_W{1'b0}};
            max_q[c]  <= {DATA_W{1'b0}};
         end
      end else begin
         col_q   <= col_d;
         row_q   <= row_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         hold_q  <= hold_d;
         max_q   <= max_d;
      end
   end

   // Half-row buffer: every entry is rewritten on an even row before the odd row reads it
   always_ff @(posedge clk) begin
      if (lb_we_s) begin
         for (int c = 0; c < 3; c++) begin
            linebuf_q[c][lb_idx_s] <= lb_wr_s[c];
         end
      end
   end

   assign max_value_1    = max_q[0];
   assign max_value_2    = max_q[1];
   assign max_value_3    = max_q[2];
   assign valid_out_pool = valid_q;
   assign frame_done     = done_q;

endmodule

// File: tb/tb_maxpool1_layer.sv
// Randomized self-checking bench for maxpool1_layer against a frame-array reference model.
module tb_maxpool1_layer;
   localparam int IMG_W  = 24;
   localparam int IMG_H  = 24;
   localparam int DATA_W = 12;
   localparam int NWIN   = (IMG_W / 2) * (IMG_H / 2);
   localparam int NPIX   = IMG_W * IMG_H;

   logic clk = 1'b0;
   logic rst;
   logic valid_in;
   logic signed [DATA_W-1:0] conv_out_1, conv_out_2, conv_out_3;
   logic signed [DATA_W-1:0] max_value_1, max_value_2, max_value_3;
   logic valid_out_pool, frame_done;

   always #5 clk = ~clk;

   maxpool1_layer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in),
      .conv_out_1(conv_out_1), .conv_out_2(conv_out_2), .conv_out_3(conv_out_3),
      .max_value_1(max_value_1), .max_value_2(max_value_2), .max_value_3(max_value_3),
      .valid_out_pool(valid_out_pool), .frame_done(frame_done)
   );

   int n_cmp = 0;
   int n_err = 0;
   logic signed [DATA_W-1:0] fpx [3][IMG_H][IMG_W];
   logic signed [DATA_W-1:0] last_exp [3];
   logic signed [DATA_W-1:0] obs1 [NWIN];
   int mr, mc, pulses, dones;

   task automatic check_val(input string tag, input logic signed [31:0] got,
                            input logic signed [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Pooled reference for the window whose bottom-right pixel is (r,c).
   function automatic logic signed [DATA_W-1:0] ref_pool(int ch, int r, int c);
      int m;
      m = fpx[ch][r][c];
      if (fpx[ch][r-1][c-1] > m) m = fpx[ch][r-1][c-1];
      if (fpx[ch][r-1][c]   > m) m = fpx[ch][r-1][c];
      if (fpx[ch][r][c-1]   > m) m = fpx[ch][r][c-1];
`ifdef MAXPOOL1_RELU_EN
      if (m < 0) m = 0;
`endif
      return DATA_W'(m);
   endfunction

   // mode 0: ramp (ch2/3 negated); 1: random; 2: random with directed windows on ch1
   task automatic fill_frame(input int mode);
      logic signed [DATA_W-1:0] rv;
      for (int r = 0; r < IMG_H; r++)
         for (int c = 0; c < IMG_W; c++)
            for (int ch = 0; ch < 3; ch++) begin
               rv = DATA_W'($urandom);
               if (mode == 0) fpx[ch][r][c] = DATA_W'((ch == 0) ? (r*IMG_W + c) : -(r*IMG_W + c));
               else fpx[ch][r][c] = rv;
            end
      if (mode == 2) begin
         fpx[0][0][0] = 12'sd5;  fpx[0][0][1] = -12'sd3; fpx[0][1][0] = 12'sd7;  fpx[0][1][1] = 12'sd100;
         fpx[0][0][2] = -12'sd8; fpx[0][0][3] = -12'sd2; fpx[0][1][2] = -12'sd5; fpx[0][1][3] = -12'sd9;
      end
   endtask

   // One clock: drive at negedge, model at posedge, check at next negedge.
   task automatic step(input logic v);
      logic exp_p, exp_d;
      valid_in = v;
      conv_out_1 = v ? fpx[0][mr][mc] : DATA_W'($urandom);
      conv_out_2 = v ? fpx[1][mr][mc] : DATA_W'($urandom);
      conv_out_3 = v ? fpx[2][mr][mc] : DATA_W'($urandom);
      @(posedge clk);
      exp_p = 1'b0;
      exp_d = 1'b0;
      if (v) begin
         if ((mr % 2 == 1) && (mc % 2 == 1)) begin
            exp_p = 1'b1;
            exp_d = (mr == IMG_H-1) && (mc == IMG_W-1);
            for (int ch = 0; ch < 3; ch++) last_exp[ch] = ref_pool(ch, mr, mc);
         end
         mc++;
         if (mc == IMG_W) begin
            mc = 0;
            mr = (mr == IMG_H-1) ? 0 : mr + 1;
         end
      end
      @(negedge clk);
      check_val("valid_out_pool", valid_out_pool, exp_p);
      check_val("frame_done", frame_done, exp_d);
      check_val("max_value_1", max_value_1, last_exp[0]);
      check_val("max_value_2", max_value_2, last_exp[1]);
      check_val("max_value_3", max_value_3, last_exp[2]);
      if (valid_out_pool) begin
         if (pulses < NWIN) obs1[pulses] = max_value_1;
         pulses++;
      end
      if (frame_done) dones++;
   endtask

   task automatic run_frame(input int mode, input int idle_pct, input int npix);
      int cnt;
      logic v;
      fill_frame(mode);
      cnt = 0;
      while (cnt < npix) begin
         v = ($urandom_range(99) >= idle_pct);
         step(v);
         if (v) cnt++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      valid_in = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      valid_in = 1'b0;
      mr = 0; mc = 0;
      for (int ch = 0; ch < 3; ch++) last_exp[ch] = '0;
      check_val("rst_max1", max_value_1, 0);
      check_val("rst_max2", max_value_2, 0);
      check_val("rst_max3", max_value_3, 0);
      check_val("rst_valid", valid_out_pool, 0);
      check_val("rst_done", frame_done, 0);
   endtask

   initial begin
      logic signed [DATA_W-1:0] neg_exp;
`ifdef MAXPOOL1_RELU_EN
      neg_exp = '0;
`else
      neg_exp = -12'sd2;
`endif
      rst = 1'b1; valid_in = 1'b0;
      conv_out_1 = '0; conv_out_2 = '0; conv_out_3 = '0;
      repeat (2) @(negedge clk);
      do_reset();

      pulses = 0; dones = 0;
      run_frame(0, 0, NPIX);
      step(1'b0);
      check_val("ramp_pulses", pulses, NWIN);
      check_val("ramp_dones", dones, 1);
      check_val("ramp_first", obs1[0], 25);
      check_val("ramp_last", obs1[NWIN-1], 575);

      pulses = 0; dones = 0;
      run_frame(2, 0, NPIX);
      check_val("dir_win0", obs1[0], 100);
      check_val("dir_negwin", obs1[1], neg_exp);
      check_val("dir_pulses", pulses, NWIN);

      pulses = 0; dones = 0;
      run_frame(0, 40, NPIX);
      check_val("stall_pulses", pulses, NWIN);
      check_val("stall_dones", dones, 1);
      check_val("stall_first", obs1[0], 25);
      check_val("stall_last", obs1[NWIN-1], 575);

      run_frame(1, 20, 30);
      do_reset();
      pulses = 0; dones = 0;
      run_frame(0, 0, NPIX);
      check_val("abort_pulses", pulses, NWIN);
      check_val("abort_first", obs1[0], 25);
      check_val("abort_last", obs1[NWIN-1], 575);

      pulses = 0; dones = 0;
      run_frame(1, 0, NPIX);
      run_frame(1, 0, NPIX);
      repeat (3) step(1'b0);
      check_val("b2b_pulses", pulses, 2*NWIN);
      check_val("b2b_dones", dones, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
